iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Multi-cycle 64-bit integer divider in the execute stage, directly downstream of the register file.
- Consumes the two register read operands (dividend = rd1, divisor = rd2) and produces quotient/remainder for writeback on the register write-data path.
- Implements LEGv8/ARMv8 UDIV and SDIV semantics with a start/busy/done handshake; the control unit stalls the PC while busy.

Parameters:
- N, 64, operand/result width in bits; iteration count of the RUN state.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request a division; sampled only in IDLE
- signed_op  input  1  1 = SDIV (two's complement), 0 = UDIV
- dividend  input  N  numerator (rd1)
- divisor  input  N  denominator (rd2)
- busy  output  1  high from the cycle after an accepted start until done is asserted
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  N  result, held until the next accepted start
- remainder  output  N  result, same sign as the dividend for SDIV, held
- div_by_zero  output  1  set with done when divisor == 0; held with results

Behaviour:
- Reset (async assert, sync deassert by the system): state = IDLE; busy, done, div_by_zero, quotient, remainder = 0; internal registers cleared.
- Reset mid-operation aborts immediately; no done is produced.
- States are IDLE, RUN, FIX.
- IDLE + start (edge 0):
  - latch |dividend|, |divisor| (absolute values only if signed_op), quotient sign = sign(dividend) XOR sign(divisor), remainder sign = sign(dividend);
  - clear the partial remainder; iteration counter = N-1; go to RUN.
  - If divisor == 0, go straight to FIX.
- RUN: one restoring step per cycle (shift partial remainder left by one, bring in the dividend MSB, trial-subtract divisor, set the quotient bit if non-negative). Counter decrements; on counter == 0 go to FIX. Exactly N cycles.
- FIX (one cycle):
  - apply two's-complement sign correction and register quotient/remainder/div_by_zero;
  - done = 1 for exactly one cycle (the cycle after the FIX edge);
  - return to IDLE.
- Latency: start sampled at edge 0 -> done high after edge N+1 (N+2 cycles total; 66 at N=64). Divide by zero: done high after edge 1.
- busy is high during RUN and FIX, and low in the done cycle, so back-to-back start is allowed in the done cycle.
- start while busy is ignored; no queueing, no error.
- Divide by zero: quotient = 0, remainder = dividend (unmodified), div_by_zero = 1.
- Signed overflow (MIN / -1): quotient = MIN (wraps), remainder = 0, no flag.
- Arithmetic width: partial remainder is N+1 bits for the trial subtraction; all results are truncated to N.
- Operands are captured at start; input changes afterwards have no effect.

Optional Feature:
- Macro: DIV_EARLY_EN.
- Defined: in IDLE, if |dividend| < |divisor| (unsigned compare of the captured magnitudes), skip RUN and go to FIX with quotient = 0 and remainder = dividend. done is high after edge 1, with the same timing as divide by zero.
- Undefined: every non-zero-divisor operation takes the full N+2 cycles.
- Results are identical either way; only latency differs.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [1:0] div_state_t {IDLE, RUN, FIX};
  - localparam DIV_W = 64;
  - localparam CNT_W = $clog2(DIV_W).
- Sub-module div_step: combinational single restoring iteration. Inputs are the partial remainder, the dividend bit and the divisor; outputs are the next partial remainder and the quotient bit.
- The top level holds the FSM, the counter and the sign handling.

Test Plan:
- UDIV 100 / 7 -> done exactly 66 cycles after start; quotient = 14, remainder = 2, div_by_zero = 0; busy high for 65 cycles.
- SDIV -100 / 7 -> quotient = -14 (0xFFFF_FFFF_FFFF_FFF2), remainder = -2; SDIV 100 / -7 -> quotient = -14, remainder = 2.
- UDIV 0xFFFF_FFFF_FFFF_FFFF / 0 -> done 2 cycles after start; quotient = 0, remainder = 0xFFFF_FFFF_FFFF_FFFF, div_by_zero = 1.
- SDIV 0x8000_0000_0000_0000 / -1 -> quotient = 0x8000_0000_0000_0000, remainder = 0; then start pulsed during RUN is ignored, and a new start in the done cycle is accepted.
- Assert reset_n = 0 at cycle 30 of a division -> busy = done = quotient = remainder = 0 immediately; no done after release; the next division completes correctly.
- With DIV_EARLY_EN, UDIV 3 / 10 -> done 2 cycles after start, quotient = 0, remainder = 3; without it, done after 66 cycles with the same results.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type and widths for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } div_state_t;

    localparam int DIV_W = 64;
    localparam int CNT_W = $clog2(DIV_W);

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_W
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;

    assign shifted = {rem_in, bit_in};
    assign trial   = shifted - {2'b00, divisor};
    // A clear top bit means the trial subtraction did not borrow.
    assign q_bit   = ~trial[N+1];
    assign rem_out = q_bit ? trial[N:0] : shifted[N:0];

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle UDIV/SDIV unit with start/busy/done handshake
// Optional DIV_EARLY_EN: skip the iterations when |dividend| < |divisor|.
module iter_divider
    import div_pkg::*;
#(
    parameter int N = DIV_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         signed_op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N == DIV_W) ? CNT_W : $clog2(N);

    div_state_t     state;
    div_state_t     state_next;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   shreg;
    logic [N:0]     part_rem;
    logic [N-1:0]   dvs;
    logic           q_neg;
    logic           r_neg;
    logic           dbz;

    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic           skip;
    logic [N:0]     step_rem;
    logic           step_q;

    assign a_neg = signed_op & dividend[N-1];
    assign b_neg = signed_op & divisor[N-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

`ifdef DIV_EARLY_EN
    assign skip = (divisor == '0) || (a_mag < b_mag);
`else
    assign skip = (divisor == '0);
`endif

    assign busy = (state == RUN) || (state == FIX);

    // shreg shifts the dividend out of its top while quotient bits fill the bottom.
    div_step #(.N(N)) u_step (
        .rem_in  (part_rem),
        .bit_in  (shreg[N-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = skip ? FIX : RUN;
            RUN:     if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            shreg       <= '0;
            part_rem    <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz         <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Skipped operations preload a zero quotient and the dividend as remainder.
                        shreg    <= skip ? '0 : a_mag;
                        part_rem <= skip ? {1'b0, a_mag} : '0;
                        dvs      <= b_mag;
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        dbz      <= (divisor == '0);
                        cnt      <= CW'(N - 1);
                    end
                end
                RUN: begin
                    part_rem <= step_rem;
                    shreg    <= {shreg[N-2:0], step_q};
                    cnt      <= cnt - CW'(1);
                end
                FIX: begin
                    quotient    <= q_neg ? -shreg : shreg;
                    remainder   <= r_neg ? -part_rem[N-1:0] : part_rem[N-1:0];
                    div_by_zero <= dbz;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - scoreboard bench for iter_divider
module tb_iter_divider;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
        int          lat;
    } exp_t;

`ifdef DIV_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        signed_op;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    iter_divider dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic op, input logic [63:0] a, input logic [63:0] b);
        exp_t        m;
        logic        an;
        logic        bn;
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] qm;
        logic [63:0] rm;
        an = op & a[63];
        bn = op & b[63];
        am = an ? -a : a;
        bm = bn ? -b : b;
        if (b == 64'd0) begin
            m.q = 64'd0; m.r = a; m.z = 1'b1; m.lat = 2;
        end else begin
            qm = am / bm;
            rm = am % bm;
            m.q = (an ^ bn) ? -qm : qm;
            m.r = an ? -rm : rm;
            m.z = 1'b0;
            m.lat = (EARLY && (am < bm)) ? 2 : 66;
        end
        return m;
    endfunction

    // Starts one division and waits (bounded) for done; returns in the done cycle at the negedge.
    task automatic issue(input logic op, input logic [63:0] a, input logic [63:0] b,
                         input bit immediate, input int poke,
                         output int lat, output int busy_cnt);
        if (!immediate) @(negedge clk);
        start = 1'b1; signed_op = op; dividend = a; divisor = b;
        busy_cnt = 0;
        @(posedge clk);
        lat = 1;
        #1 start = 1'b0; dividend = ~a; divisor = ~b; signed_op = ~op;
        while (lat < 200) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cnt++;
            if (lat == poke) begin
                start = 1'b1; dividend = 64'd5; divisor = 64'd1;
            end
            @(posedge clk);
            lat++;
            #1 start = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, div_by_zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); else passes++;
        checks++; if ({quotient, remainder} !== 128'd0) $display("FAIL reset_results got %h/%h want 0/0", quotient, remainder); else passes++;
        reset_n = 1'b1;
    endtask

    task automatic test_udiv;
        int lat, bc;
        exp_t e;
        sb.push_back('{q: 64'd14, r: 64'd2, z: 1'b0, lat: 66});
        issue(1'b0, 64'd100, 64'd7, 1'b0, -1, lat, bc);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) $display("FAIL udiv_latency got %0d want %0d", lat, e.lat); else passes++;
        checks++; if (bc !== 65) $display("FAIL udiv_busy_cycles got %0d want 65", bc); else passes++;
        checks++; if (quotient !== e.q) $display("FAIL udiv_q got %h want %h", quotient, e.q); else passes++;
        checks++; if (remainder !== e.r) $display("FAIL udiv_r got %h want %h", remainder, e.r); else passes++;
        checks++; if (div_by_zero !== e.z) $display("FAIL udiv_dbz got %b want %b", div_by_zero, e.z); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL udiv_done_pulse got %b want 0", done); else passes++;
        checks++; if (quotient !== e.q) $display("FAIL udiv_q_held got %h want %h", quotient, e.q); else passes++;
    endtask

    task automatic test_sdiv;
        int lat, bc;
        exp_t e;
        logic [63:0] a [2];
        logic [63:0] b [2];
        a[0] = -64'd100; b[0] = 64'd7;
        a[1] = 64'd100;  b[1] = -64'd7;
        sb.push_back('{q: 64'hFFFF_FFFF_FFFF_FFF2, r: -64'd2, z: 1'b0, lat: 66});
        sb.push_back('{q: 64'hFFFF_FFFF_FFFF_FFF2, r: 64'd2, z: 1'b0, lat: 66});
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, a[i], b[i], 1'b0, -1, lat, bc);
            e = sb.pop_front();
            checks++; if (lat !== e.lat) $display("FAIL sdiv%0d_latency got %0d want %0d", i, lat, e.lat); else passes++;
            checks++; if (quotient !== e.q) $display("FAIL sdiv%0d_q got %h want %h", i, quotient, e.q); else passes++;
            checks++; if (remainder !== e.r) $display("FAIL sdiv%0d_r got %h want %h", i, remainder, e.r); else passes++;
        end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        exp_t e;
        sb.push_back('{q: 64'd0, r: 64'hFFFF_FFFF_FFFF_FFFF, z: 1'b1, lat: 2});
        sb.push_back('{q: 64'd0, r: -64'd5, z: 1'b1, lat: 2});
        for (int i = 0; i < 2; i++) begin
            if (i == 0) issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, -1, lat, bc);
            else        issue(1'b1, -64'd5, 64'd0, 1'b0, -1, lat, bc);
            e = sb.pop_front();
            checks++; if (lat !== e.lat) $display("FAIL dbz%0d_latency got %0d want %0d", i, lat, e.lat); else passes++;
            checks++; if (quotient !== e.q) $display("FAIL dbz%0d_q got %h want %h", i, quotient, e.q); else passes++;
            checks++; if (remainder !== e.r) $display("FAIL dbz%0d_r got %h want %h", i, remainder, e.r); else passes++;
            checks++; if (div_by_zero !== e.z) $display("FAIL dbz%0d_flag got %b want %b", i, div_by_zero, e.z); else passes++;
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        exp_t e;
        sb.push_back('{q: MIN, r: 64'd0, z: 1'b0, lat: 66});
        sb.push_back('{q: 64'd100, r: 64'd0, z: 1'b0, lat: 66});
        issue(1'b1, MIN, -64'd1, 1'b0, 10, lat, bc);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) $display("FAIL ovf_latency got %0d want %0d", lat, e.lat); else passes++;
        checks++; if (quotient !== e.q) $display("FAIL ovf_q got %h want %h", quotient, e.q); else passes++;
        checks++; if (remainder !== e.r) $display("FAIL ovf_r got %h want %h", remainder, e.r); else passes++;
        checks++; if (div_by_zero !== e.z) $display("FAIL ovf_dbz got %b want %b", div_by_zero, e.z); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_in_done got %b want 0", busy); else passes++;
        issue(1'b0, 64'd1000, 64'd10, 1'b1, -1, lat, bc);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) $display("FAIL b2b_latency got %0d want %0d", lat, e.lat); else passes++;
        checks++; if (quotient !== e.q) $display("FAIL b2b_q got %h want %h", quotient, e.q); else passes++;
        checks++; if (remainder !== e.r) $display("FAIL b2b_r got %h want %h", remainder, e.r); else passes++;
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        bit seen;
        exp_t e;
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 64'd12345; divisor = 64'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL midrst_flags got %b want 00", {busy, done}); else passes++;
        checks++; if ({quotient, remainder} !== 128'd0) $display("FAIL midrst_results got %h/%h want 0/0", quotient, remainder); else passes++;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL midrst_no_done got %b want 0", seen); else passes++;
        sb.push_back('{q: 64'd1763, r: 64'd4, z: 1'b0, lat: 66});
        issue(1'b0, 64'd12345, 64'd7, 1'b0, -1, lat, bc);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) $display("FAIL midrst_next_latency got %0d want %0d", lat, e.lat); else passes++;
        checks++; if (quotient !== e.q) $display("FAIL midrst_next_q got %h want %h", quotient, e.q); else passes++;
        checks++; if (remainder !== e.r) $display("FAIL midrst_next_r got %h want %h", remainder, e.r); else passes++;
    endtask

    task automatic test_early;
        int lat, bc;
        exp_t e;
        sb.push_back('{q: 64'd0, r: 64'd3, z: 1'b0, lat: EARLY ? 2 : 66});
        issue(1'b0, 64'd3, 64'd10, 1'b0, -1, lat, bc);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) $display("FAIL early_latency got %0d want %0d", lat, e.lat); else passes++;
        checks++; if (quotient !== e.q) $display("FAIL early_q got %h want %h", quotient, e.q); else passes++;
        checks++; if (remainder !== e.r) $display("FAIL early_r got %h want %h", remainder, e.r); else passes++;
        checks++; if (div_by_zero !== e.z) $display("FAIL early_dbz got %b want %b", div_by_zero, e.z); else passes++;
    endtask

    task automatic test_random;
        int lat, bc;
        exp_t e;
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        for (int i = 0; i < 8; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = (i % 2 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            if (i == 3) b = -b;
            sb.push_back(model(op, a, b));
            issue(op, a, b, 1'b0, -1, lat, bc);
            e = sb.pop_front();
            checks++; if (lat !== e.lat) $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, e.lat); else passes++;
            checks++; if (quotient !== e.q) $display("FAIL rnd%0d_q got %h want %h (op %b a %h b %h)", i, quotient, e.q, op, a, b); else passes++;
            checks++; if (remainder !== e.r) $display("FAIL rnd%0d_r got %h want %h (op %b a %h b %h)", i, remainder, e.r, op, a, b); else passes++;
            checks++; if (div_by_zero !== e.z) $display("FAIL rnd%0d_dbz got %b want %b", i, div_by_zero, e.z); else passes++;
        end
    endtask

    initial begin
        test_reset;
        test_udiv;
        test_sdiv;
        test_div_zero;
        test_back_to_back;
        test_reset_mid;
        test_early;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
